// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one step per clock, fixed W_CPU-cycle latency.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// RUN   | iterating; completes on the W_CPU-th edge after launch
module muldiv_unit #(
    parameter int W_CPU = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [W_CPU-1:0] a,
    input  logic [W_CPU-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [W_CPU-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [W_CPU-1:0] hi,
    output logic [W_CPU-1:0] lo
);
    localparam int CW = $clog2(W_CPU);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic                 launch, last;
    logic [CW-1:0]        cnt;
    logic                 is_div, neg_res, neg_rem, div0;
    logic [W_CPU-1:0]     x, y, rem;
    logic [2*W_CPU-1:0]   acc;

    logic                 sgn, a_neg, b_neg;
    logic [W_CPU-1:0]     a_mag, b_mag;
    logic [W_CPU:0]       sum, trial;
    logic [W_CPU-1:0]     x_nxt, rem_nxt;
    logic [2*W_CPU-1:0]   acc_nxt, prod;
    logic [W_CPU-1:0]     hi_res, lo_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(W_CPU - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // op[0]=0 selects the signed flavour of both mult and div
    always_comb begin
        sgn   = ~op[0];
        a_neg = sgn & a[W_CPU-1];
        b_neg = sgn & b[W_CPU-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // x is the multiplier (shifted right) or the dividend/quotient (shifted left);
    // y is the multiplicand or divisor.
    always_comb begin
        acc_nxt = acc;
        x_nxt   = x;
        rem_nxt = rem;
        sum     = {1'b0, acc[2*W_CPU-1:W_CPU]} + (x[0] ? {1'b0, y} : '0);
        trial   = {rem, x[W_CPU-1]};
        if (is_div) begin
            if (trial >= {1'b0, y}) begin
                rem_nxt = W_CPU'(trial - {1'b0, y});
                x_nxt   = {x[W_CPU-2:0], 1'b1};
            end else begin
                rem_nxt = trial[W_CPU-1:0];
                x_nxt   = {x[W_CPU-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {sum, acc[W_CPU-1:1]};
            x_nxt   = {1'b0, x[W_CPU-1:1]};
        end
    end

    // Divide by zero leaves |a| in the remainder, so the dividend-sign fix restores a.
    always_comb begin
        prod   = neg_res ? -acc_nxt : acc_nxt;
        hi_res = prod[2*W_CPU-1:W_CPU];
        lo_res = prod[W_CPU-1:0];
        if (is_div) begin
            hi_res = neg_rem ? -rem_nxt : rem_nxt;
            lo_res = div0 ? '1 : (neg_res ? -x_nxt : x_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            x       <= '0;
            y       <= '0;
            rem     <= '0;
            acc     <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= last;
            if (launch) begin
                is_div  <= op[1];
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                div0    <= op[1] & (b == '0);
                x       <= op[1] ? a_mag : b_mag;
                y       <= op[1] ? b_mag : a_mag;
                rem     <= '0;
                acc     <= '0;
                cnt     <= '0;
            end else if (busy) begin
                acc <= acc_nxt;
                x   <= x_nxt;
                rem <= rem_nxt;
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                hi <= hi_res;
                lo <= lo_res;
            end else if (!busy) begin
                if (mthi) hi <= wd;
                if (mtlo) lo <= wd;
            end
        end
    end
endmodule
